// File: rtl/morse_keyer_sequencer_if.sv
// Symbol handshake between the character encoder (master) and the keyer (slave).
// A symbol moves across when sym_valid and sym_ready are both high at a rising clock edge.
interface morse_keyer_sequencer_if;
   logic       sym_valid;
   logic       sym_ready;
   logic [4:0] sym_code;
   logic [2:0] sym_len;

   modport master (
      output sym_valid,
      output sym_code,
      output sym_len,
      input  sym_ready
   );

   modport slave (
      input  sym_valid,
      input  sym_code,
      input  sym_len,
      output sym_ready
   );
endinterface

// File: rtl/morse_keyer_sequencer.sv
// Morse keyer: turns one dot/dash symbol at a time into an on/off keying line.
// Standard unit timing comes from a programmable unit-period counter.
module morse_keyer_sequencer #(
   parameter int unsigned UNIT_CYCLES = 100000000,
   parameter int unsigned CNT_W       = 28
) (
   input  logic                          clk,
   input  logic                          rst_n,
   morse_keyer_sequencer_if.slave        sym_if,
   input  logic                          abort_i,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic                          done_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_MARK  = 3'd1;
   localparam logic [2:0] S_SPACE = 3'd2;
   localparam logic [2:0] S_LGAP  = 3'd3;
   localparam logic [2:0] S_WGAP  = 3'd4;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(UNIT_CYCLES - 1);

   logic [2:0]       state_q,  state_d;
   logic [4:0]       shift_q,  shift_d;
   logic [2:0]       rem_q,    rem_d;
   logic [1:0]       unit_q,   unit_d;
   logic [CNT_W-1:0] period_q, period_d;
   logic             tx_q,     tx_d;
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;

   logic             accept;
   logic             tick;
   logic             elapsed;
   logic [1:0]       unit_last;
   logic [2:0]       len_clamped;

   assign sym_if.sym_ready = (state_q == S_IDLE);
   assign accept           = sym_if.sym_valid && sym_if.sym_ready;
   assign tick             = (state_q != S_IDLE) && (period_q == LAST_CNT);
   assign len_clamped      = (sym_if.sym_len > 3'd5) ? 3'd5 : sym_if.sym_len;

   // Units to hold the current state, minus one; the word gap needs 4 and fits in 2 bits that way.
   always_comb begin
      unit_last = 2'd0;
      case (state_q)
         S_MARK:  unit_last = shift_q[0] ? 2'd2 : 2'd0;
         S_SPACE: unit_last = 2'd0;
         S_LGAP:  unit_last = 2'd2;
         S_WGAP:  unit_last = 2'd3;
         default: unit_last = 2'd0;
      endcase
   end

   assign elapsed = tick && (unit_q == unit_last);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      rem_d    = rem_q;
      unit_d   = unit_q;
      period_d = '0;
      tx_d     = tx_q;
      done_d   = 1'b0;

      if (state_q != S_IDLE) begin
         period_d = tick ? '0 : period_q + CNT_W'(1);
      end
      if (tick) begin
         unit_d = elapsed ? 2'd0 : unit_q + 2'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               shift_d  = sym_if.sym_code;
               rem_d    = len_clamped;
               unit_d   = 2'd0;
               period_d = '0;
               if (len_clamped == 3'd0) begin
                  state_d = S_WGAP;
                  tx_d    = 1'b0;
               end else begin
                  state_d = S_MARK;
                  tx_d    = 1'b1;
               end
            end
         end
         S_MARK: begin
            if (elapsed) begin
               tx_d = 1'b0;
               if (rem_q > 3'd1) begin
                  state_d = S_SPACE;
                  rem_d   = rem_q - 3'd1;
                  shift_d = {1'b0, shift_q[4:1]};
               end else begin
                  state_d = S_LGAP;
               end
            end
         end
         S_SPACE: begin
            if (elapsed) begin
               state_d = S_MARK;
               tx_d    = 1'b1;
            end
         end
         S_LGAP, S_WGAP: begin
            if (elapsed) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tx_d    = 1'b0;
         end
      endcase

      // Abort wins over a tick landing in the same cycle, including the final one of a gap.
      if (abort_i && (state_q != S_IDLE)) begin
         state_d  = S_IDLE;
         tx_d     = 1'b0;
         done_d   = 1'b0;
         rem_d    = 3'd0;
         unit_d   = 2'd0;
         period_d = '0;
      end

      busy_d = (state_d != S_IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         rem_q    <= '0;
         unit_q   <= '0;
         period_q <= '0;
         tx_q     <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         shift_q  <= shift_d;
         rem_q    <= rem_d;
         unit_q   <= unit_d;
         period_q <= period_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign tx_o   = tx_q;
   assign busy_o = busy_q;
   assign done_o = done_q;

endmodule

// File: tb/tb_morse_keyer_sequencer.sv
// Scoreboard bench for morse_keyer_sequencer at UNIT_CYCLES=4: stimulus queues expected
// TX/BUSY edges and DONE pulses by absolute cycle, a negedge monitor pops and compares them.
module tb_morse_keyer_sequencer;

   typedef struct {
      int   cyc;
      logic val;
   } ev_t;

   logic clk;
   logic rst_n;
   logic abort_i;
   logic tx_o;
   logic busy_o;
   logic done_o;

   int   cyc;
   int   n_checks;
   int   n_pass;
   bit   mon_en;
   logic prev_tx;
   logic prev_busy;

   ev_t  tx_exp[$];
   ev_t  busy_exp[$];
   int   done_exp[$];

   morse_keyer_sequencer_if sif ();

   morse_keyer_sequencer #(
      .UNIT_CYCLES (4),
      .CNT_W       (28)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .sym_if  (sif),
      .abort_i (abort_i),
      .tx_o    (tx_o),
      .busy_o  (busy_o),
      .done_o  (done_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      cyc       = 0;
      n_checks  = 0;
      n_pass    = 0;
      mon_en    = 1'b0;
      prev_tx   = 1'b0;
      prev_busy = 1'b0;
   end

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input bit ok, input string detail);
      n_checks = n_checks + 1;
      if (ok) n_pass = n_pass + 1;
      else    $display("FAIL %s: %s", name, detail);
   endtask

   task automatic exp_tx(input int base, input int rise, input int fall);
      ev_t e;
      e.cyc = base + rise; e.val = 1'b1; tx_exp.push_back(e);
      e.cyc = base + fall; e.val = 1'b0; tx_exp.push_back(e);
   endtask

   task automatic exp_busy(input int base, input int rise, input int fall);
      ev_t e;
      e.cyc = base + rise; e.val = 1'b1; busy_exp.push_back(e);
      e.cyc = base + fall; e.val = 1'b0; busy_exp.push_back(e);
   endtask

   task automatic exp_done(input int base, input int rel);
      done_exp.push_back(base + rel);
   endtask

   // Called at a negedge; returns the absolute cycle of the accepting posedge.
   task automatic offer(input logic [4:0] code, input logic [2:0] len, output int acc);
      sif.sym_code  = code;
      sif.sym_len   = len;
      sif.sym_valid = 1'b1;
      acc = -1000;
      for (int i = 0; i < 200; i++) begin
         if (sif.sym_ready === 1'b1) begin
            acc = cyc + 1;
            break;
         end
         @(negedge clk);
      end
      if (acc == -1000)
         check("accept_timeout", 1'b0, $sformatf("got no sym_ready within 200 cycles at cycle %0d, want ready", cyc));
   endtask

   // Monitor: every TX/BUSY change and every DONE-high cycle must match the head of its queue.
   always @(negedge clk) begin
      if (mon_en) begin
         if (tx_o !== prev_tx) begin
            if (tx_exp.size() == 0) begin
               check("tx_unexpected", 1'b0, $sformatf("got tx->%0b at cycle %0d, want no edge", tx_o, cyc + 1));
            end else begin
               check("tx_edge", (tx_exp[0].cyc == cyc + 1) && (tx_exp[0].val === tx_o),
                     $sformatf("got tx->%0b at cycle %0d, want tx->%0b at cycle %0d",
                               tx_o, cyc + 1, tx_exp[0].val, tx_exp[0].cyc));
               void'(tx_exp.pop_front());
            end
         end
         if (busy_o !== prev_busy) begin
            if (busy_exp.size() == 0) begin
               check("busy_unexpected", 1'b0, $sformatf("got busy->%0b at cycle %0d, want no edge", busy_o, cyc + 1));
            end else begin
               check("busy_edge", (busy_exp[0].cyc == cyc + 1) && (busy_exp[0].val === busy_o),
                     $sformatf("got busy->%0b at cycle %0d, want busy->%0b at cycle %0d",
                               busy_o, cyc + 1, busy_exp[0].val, busy_exp[0].cyc));
               void'(busy_exp.pop_front());
            end
         end
         if (done_o !== 1'b0) begin
            if (done_exp.size() == 0) begin
               check("done_unexpected", 1'b0, $sformatf("got done=%0b at cycle %0d, want 0", done_o, cyc + 1));
            end else begin
               check("done_pulse", done_exp[0] == cyc + 1,
                     $sformatf("got done at cycle %0d, want cycle %0d", cyc + 1, done_exp[0]));
               void'(done_exp.pop_front());
            end
         end
      end
      prev_tx   <= tx_o;
      prev_busy <= busy_o;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got time limit reached at cycle %0d, want bench complete", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      int a;
      int b;

      rst_n         = 1'b0;
      abort_i       = 1'b0;
      sif.sym_valid = 1'b0;
      sif.sym_code  = 5'b0;
      sif.sym_len   = 3'd0;
      repeat (3) @(negedge clk);
      check("rst_tx",    tx_o === 1'b0,          $sformatf("got %b, want 0", tx_o));
      check("rst_busy",  busy_o === 1'b0,        $sformatf("got %b, want 0", busy_o));
      check("rst_done",  done_o === 1'b0,        $sformatf("got %b, want 0", done_o));
      check("rst_ready", sif.sym_ready === 1'b1, $sformatf("got %b, want 1", sif.sym_ready));
      rst_n  = 1'b1;
      mon_en = 1'b1;
      @(negedge clk);

      // Letter E: one dot
      offer(5'b00000, 3'd1, a);
      exp_tx(a, 1, 5); exp_busy(a, 1, 17); exp_done(a, 17);
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (20) @(negedge clk);

      // Letter A, then T offered continuously
      offer(5'b00010, 3'd2, a);
      exp_tx(a, 1, 5); exp_tx(a, 9, 21); exp_busy(a, 1, 33); exp_done(a, 33);
      @(negedge clk);
      offer(5'b00001, 3'd1, b);
      check("back_to_back_accept", b == a + 33, $sformatf("got accept at cycle %0d, want %0d", b - a, 33));
      exp_tx(b, 1, 13); exp_busy(b, 1, 25); exp_done(b, 25);
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (30) @(negedge clk);

      // Word space, with an ignored symbol offered at cycle 5
      offer(5'b00000, 3'd0, a);
      exp_busy(a, 1, 17); exp_done(a, 17);
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (4) @(negedge clk);
      sif.sym_code  = 5'b00000;
      sif.sym_len   = 3'd1;
      sif.sym_valid = 1'b1;
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (20) @(negedge clk);

      // Length 7 clamps to five dashes
      offer(5'b11111, 3'd7, a);
      for (int i = 0; i < 5; i++) exp_tx(a, 1 + 16 * i, 13 + 16 * i);
      exp_busy(a, 1, 89); exp_done(a, 89);
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (95) @(negedge clk);

      // Abort at cycle 6 of a dash, then a fresh E
      offer(5'b00001, 3'd1, a);
      exp_tx(a, 1, 7); exp_busy(a, 1, 7);
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (5) @(negedge clk);
      abort_i = 1'b1;
      @(negedge clk);
      abort_i = 1'b0;
      check("abort_ready", sif.sym_ready === 1'b1, $sformatf("got %b, want 1", sif.sym_ready));
      offer(5'b00000, 3'd1, b);
      check("abort_reaccept", b == a + 7, $sformatf("got accept at cycle %0d, want %0d", b - a, 7));
      exp_tx(b, 1, 5); exp_busy(b, 1, 17); exp_done(b, 17);
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (20) @(negedge clk);

      // Reset mid-dash: outputs clear at once, the lost symbol never reports DONE
      offer(5'b00001, 3'd1, a);
      exp_tx(a, 1, 7); exp_busy(a, 1, 7);
      @(negedge clk);
      sif.sym_valid = 1'b0;
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_tx",    tx_o === 1'b0,          $sformatf("got %b, want 0", tx_o));
      check("midrst_busy",  busy_o === 1'b0,        $sformatf("got %b, want 0", busy_o));
      check("midrst_done",  done_o === 1'b0,        $sformatf("got %b, want 0", done_o));
      check("midrst_ready", sif.sym_ready === 1'b1, $sformatf("got %b, want 1", sif.sym_ready));
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (40) @(negedge clk);

      check("tx_queue_drained",   tx_exp.size() == 0,   $sformatf("got %0d pending, want 0", tx_exp.size()));
      check("busy_queue_drained", busy_exp.size() == 0, $sformatf("got %0d pending, want 0", busy_exp.size()));
      check("done_queue_drained", done_exp.size() == 0, $sformatf("got %0d pending, want 0", done_exp.size()));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
